// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 control unit: opcodes, control-word bit
// positions, one-hot T-state encodings and the fixed fetch/execute words.
package sap_pkg;

  localparam int CW_WIDTH = 12;

  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Single-bit mask for one control line.
  function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
    cw_bit = {{(CW_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  localparam logic [CW_WIDTH-1:0] CW_NONE    = 12'h000;
  localparam logic [CW_WIDTH-1:0] CW_FETCH_1 = cw_bit(CW_EP) | cw_bit(CW_LM);
  localparam logic [CW_WIDTH-1:0] CW_FETCH_2 = cw_bit(CW_CP);
  localparam logic [CW_WIDTH-1:0] CW_FETCH_3 = cw_bit(CW_CE) | cw_bit(CW_LI);
  localparam logic [CW_WIDTH-1:0] CW_ADDR    = cw_bit(CW_EI) | cw_bit(CW_LM);
  localparam logic [CW_WIDTH-1:0] CW_MEM_A   = cw_bit(CW_CE) | cw_bit(CW_LA);
  localparam logic [CW_WIDTH-1:0] CW_MEM_B   = cw_bit(CW_CE) | cw_bit(CW_LB);
  localparam logic [CW_WIDTH-1:0] CW_SUM_A   = cw_bit(CW_EU) | cw_bit(CW_LA);
  localparam logic [CW_WIDTH-1:0] CW_DIFF_A  = cw_bit(CW_SU) | cw_bit(CW_EU) | cw_bit(CW_LA);
  localparam logic [CW_WIDTH-1:0] CW_OUTPUT  = cw_bit(CW_EA) | cw_bit(CW_LO);

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot six-state ring T1..T6 with clock enable, synchronous reset and a
// freeze input that holds the current state.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_freeze,
  output logic [5:0] o_t_state
);

  logic [5:0] t_state_r;

  // Ring advance; any non-one-hot value recovers to T1 on the next step.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      t_state_r <= T1;
    end else if (i_enable && !i_freeze) begin
      case (t_state_r)
        T1:      t_state_r <= T2;
        T2:      t_state_r <= T3;
        T3:      t_state_r <= T4;
        T4:      t_state_r <= T5;
        T5:      t_state_r <= T6;
        T6:      t_state_r <= T1;
        default: t_state_r <= T1;
      endcase
    end else begin
      t_state_r <= t_state_r;
    end
  end

  assign o_t_state = t_state_r;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: ring-counter sequencing, opcode decode into the
// 12-bit control word, and the sticky HLT condition.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int NUM_T_STATES = 6,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic [CW_WIDTH-1:0]     o_control,
  output logic [NUM_T_STATES-1:0] o_t_state,
  output logic                    o_halt
);

  logic [5:0]          t_state_s;
  logic                hlt_at_t4_s;
  logic                freeze_s;
  logic                halted_r;
  logic [CW_WIDTH-1:0] control_s;

  assign hlt_at_t4_s = (t_state_s == T4) && (i_opcode == OP_HLT);
  // Freeze in the same edge that sets halted so the ring stays parked in T4.
  assign freeze_s    = halted_r | hlt_at_t4_s;

  sap_ring_counter u_ring (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_freeze  (freeze_s),
    .o_t_state (t_state_s)
  );

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      halted_r <= 1'b0;
    end else if (i_enable && hlt_at_t4_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // Moore decode of T-state and opcode into the control word.
  always_comb begin
    control_s = CW_NONE;
    if (halted_r) begin
      control_s = CW_NONE;
    end else begin
      case (t_state_s)
        T1: control_s = CW_FETCH_1;
        T2: control_s = CW_FETCH_2;
        T3: control_s = CW_FETCH_3;
        T4: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB: control_s = CW_ADDR;
            OP_OUT:                 control_s = CW_OUTPUT;
            default:                control_s = CW_NONE;
          endcase
        end
        T5: begin
          case (i_opcode)
            OP_LDA:         control_s = CW_MEM_A;
            OP_ADD, OP_SUB: control_s = CW_MEM_B;
            default:        control_s = CW_NONE;
          endcase
        end
        T6: begin
          case (i_opcode)
            OP_ADD:  control_s = CW_SUM_A;
            OP_SUB:  control_s = CW_DIFF_A;
            default: control_s = CW_NONE;
          endcase
        end
        default: control_s = CW_NONE;
      endcase
    end
  end

  assign o_control = control_s;
  assign o_t_state = t_state_s;
  assign o_halt    = halted_r;

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
Control unit for the SAP-1 datapath.
- A 6-state ring counter (T1..T6) steps through each machine cycle.
- It decodes the 4-bit opcode from the instruction register and drives the 12-bit control word: program counter increment/enable, MAR/IR/A/B/output loads, RAM/IR/adder/A enables, subtract.
- It owns fetch sequencing and the HLT stop condition.

Parameters:
- NUM_T_STATES, 6, ring length; fixed at 6, other values are unsupported.
- OPCODE_WIDTH, 4, width of i_opcode.

Ports:
- i_clock  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset; returns to T1 and clears halt.
- i_enable  in  1  clock enable; when low, T-state and halt hold and outputs are unchanged.
- i_opcode  in  4  instruction register upper nibble; must be valid from T4 through T6.
- o_control  out  12  control word, all bits active-high, bit order per package: [11]CP [10]EP [9]LM [8]CE [7]LI [6]EI [5]LA [4]EA [3]SU [2]EU [1]LB [0]LO.
- o_t_state  out  6  one-hot current T-state; bit0 = T1.
- o_halt  out  1  high once HLT executes; stays high until reset.

Behaviour:
- State register: one-hot ring T1→T2→T3→T4→T5→T6→T1, advancing on each rising edge where i_enable=1 and not halted. A separate halted flag is kept.
- Reset (sync): at the edge with i_reset=1, T-state becomes 6'b000001 and halted becomes 0, regardless of i_enable. This applies mid-instruction too, e.g. reset in T5 gives T1 on the next cycle with no T6 word emitted.
- Reset values: o_t_state=6'b000001, o_halt=0, o_control=EP|LM (12'h600).
- o_control is a combinational (Moore) decode of the registered T-state and i_opcode. Zero latency: the word is valid for the full cycle of its T-state and is consumed by the datapath at the next rising edge.
- Fetch, independent of opcode:
  - T1 = EP,LM
  - T2 = CP
  - T3 = CE,LI
- Execute:
  - LDA 0000: T4 EI,LM; T5 CE,LA; T6 none.
  - ADD 0001: T4 EI,LM; T5 CE,LB; T6 EU,LA.
  - SUB 0010: T4 EI,LM; T5 CE,LB; T6 SU,EU,LA.
  - OUT 1110: T4 EA,LO; T5 none; T6 none.
  - HLT 1111: T4 none. At the T4 edge, halted is set and the T-state freezes at T4.
  - Any other opcode: NOP. T4–T6 all zero; the ring still completes to T1.
- Halted: o_control=0, o_halt=1, o_t_state frozen at 6'b001000. Only i_reset exits.
- i_enable=0: the state register holds. o_control still reflects the current state and opcode; the datapath must be gated by the same enable.
- Simultaneous events:
  - Reset wins over enable, halt and opcode.
  - HLT in T4 with i_enable=0 does not halt until an enabled edge.
- Bus exclusivity invariant: at most one of EP, CE, EI, EA, EU is high in any cycle, halted included.

Decomposition:
- Shared package sap_pkg:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - control-bit index constants CW_CP..CW_LO
  - CW_WIDTH=12
  - T-state one-hot constants T1..T6
- Natural sub-module: sap_ring_counter, the one-hot 6-state ring with enable, sync reset and freeze input. The controller wraps it with the decode logic and halt flag.

Test Plan:
- Reset then 3 enabled cycles with opcode don't-care → o_control 12'h600, 12'h800, 12'h180; o_t_state 01, 02, 04 (hex).
- i_opcode=0001 (ADD) over T4..T6 → 12'h240, 12'h102, 12'h024. SUB 0010 → T6 12'h02C. Next cycle returns to T1 with 12'h600.
- i_opcode=1110 (OUT) → T4 12'h011; T5/T6 12'h000. Opcode 0111 → T4..T6 all 12'h000, ring completes.
- i_opcode=1111 at T4 → after the edge, o_halt=1, o_control=0, o_t_state=6'b001000 held for 20 cycles. Then i_reset=1 for one edge → o_halt=0, T1, 12'h600.
- i_enable=0 for 5 cycles while in T3 → o_t_state stays 6'b000100 and o_control stays 12'h180. Re-enable → T4 on the next edge.
- i_reset asserted in T5 of LDA, coincident with i_enable=0 → T1 after the edge. Check the one-hot and bus-exclusivity assertions every cycle over 1000 random opcode/enable/reset cycles.
